// File: rtl/pipe_pkg.sv
// Shared definitions for the datapath pipeline register bank: default bundle
// widths, the NOP control word and the bit positions of the control fields.
package pipe_pkg;

  // Default bundle widths for the RISC-V datapath
  localparam int DATA_W_DEF = 96;
  localparam int CTRL_W_DEF = 12;

  // Control word that makes a stage inert: no register write, no memory write
  localparam logic [CTRL_W_DEF-1:0] CTRL_NOP_DEF = '0;

  // Control-field layout within the default 12-bit control bundle
  localparam int PC_MUX_LSB   = 0;   // [1:0] next-PC select
  localparam int PC_MUX_W     = 2;
  localparam int WREN_RF_BIT  = 2;   // register-file write enable
  localparam int WD_MUX_BIT   = 3;   // write-back data select
  localparam int RBYTEEN_LSB  = 4;   // [5:4] load size code
  localparam int RBYTEEN_W    = 2;
  localparam int WBYTEEN_LSB  = 6;   // [9:6] store byte enables
  localparam int WBYTEEN_W    = 4;
  localparam int DM_MUX_LSB   = 10;  // [11:10] data-memory result select
  localparam int DM_MUX_W     = 2;

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage: valid, control and data registers with the
// kill / stall / NOP rules. A stage that ends up empty always carries the
// NOP control word, so no write enable can fire from a bubble.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 DATA_W   = DATA_W_DEF,
  parameter int                 CTRL_W   = CTRL_W_DEF,
  parameter logic [CTRL_W-1:0]  CTRL_NOP = CTRL_W'(CTRL_NOP_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              kill,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  input  logic [CTRL_W-1:0] src_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  logic              valid_reg;
  logic [DATA_W-1:0] data_reg;
  logic [CTRL_W-1:0] ctrl_reg;

  // Stage registers: reset > kill > stall > advance. Data follows stall only;
  // it is cleared on reset so the post-reset state is fully defined.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= 1'b0;
      ctrl_reg  <= CTRL_NOP;
      data_reg  <= '0;
    end else begin
      if (!stall) begin
        data_reg <= src_data;
      end
      if (kill) begin
        valid_reg <= 1'b0;
        ctrl_reg  <= CTRL_NOP;
      end else if (!stall) begin
        valid_reg <= src_valid;
        ctrl_reg  <= src_valid ? src_ctrl : CTRL_NOP;
      end
    end
  end

  assign valid = valid_reg;
  assign data  = data_reg;
  assign ctrl  = ctrl_reg;

endmodule

// File: rtl/pipe_stage_bank.sv
// Parametrised pipeline register bank carrying data and control bundles
// through STAGES (1..4) registered stages with global stall and per-stage kill.
// Optional feature macro: PIPE_STAGE_BANK_PERF_EN adds stall/kill counters.
module pipe_stage_bank
  import pipe_pkg::*;
#(
  parameter int                 DATA_W   = DATA_W_DEF,
  parameter int                 CTRL_W   = CTRL_W_DEF,
  parameter int                 STAGES   = 2,
  parameter logic [CTRL_W-1:0]  CTRL_NOP = CTRL_W'(CTRL_NOP_DEF)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [CTRL_W-1:0]        in_ctrl,
  input  logic                     stall,
  input  logic [STAGES-1:0]        kill,
  output logic [STAGES-1:0]        out_valid,
  output logic [STAGES*DATA_W-1:0] out_data,
  output logic [STAGES*CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_BANK_PERF_EN
  ,
  output logic [31:0]              perf_stall_cnt,
  output logic [31:0]              perf_kill_cnt
`endif
);

  // Source of each stage: stage 0 takes the inputs, stage i takes stage i-1
  logic [STAGES-1:0] src_valid;
  logic [DATA_W-1:0] src_data [STAGES];
  logic [CTRL_W-1:0] src_ctrl [STAGES];

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_src_in
        assign src_valid[gi] = in_valid;
        assign src_data[gi]  = in_data;
        assign src_ctrl[gi]  = in_ctrl;
      end else begin : g_src_prev
        assign src_valid[gi] = out_valid[gi-1];
        assign src_data[gi]  = out_data[(gi-1)*DATA_W +: DATA_W];
        assign src_ctrl[gi]  = out_ctrl[(gi-1)*CTRL_W +: CTRL_W];
      end

      pipe_stage_reg #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .CTRL_NOP (CTRL_NOP)
      ) u_stage (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .kill      (kill[gi]),
        .src_valid (src_valid[gi]),
        .src_data  (src_data[gi]),
        .src_ctrl  (src_ctrl[gi]),
        .valid     (out_valid[gi]),
        .data      (out_data[gi*DATA_W +: DATA_W]),
        .ctrl      (out_ctrl[gi*CTRL_W +: CTRL_W])
      );
    end
  endgenerate

`ifdef PIPE_STAGE_BANK_PERF_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] kill_cnt_reg;
  logic [2:0]  kill_hits;
  logic [32:0] kill_sum;
  logic [32:0] stall_sum;

  // A kill only counts when it removes a real entry: the held entry while
  // stalled, otherwise the entry that would have been loaded.
  always_comb begin
    kill_hits = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (kill[i] && (stall ? out_valid[i] : src_valid[i])) begin
        kill_hits = kill_hits + 3'd1;
      end
    end
    kill_sum  = {1'b0, kill_cnt_reg} + {30'd0, kill_hits};
    stall_sum = {1'b0, stall_cnt_reg} + 33'd1;
  end

  // Saturating performance counters, cleared on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= '0;
      kill_cnt_reg  <= '0;
    end else begin
      if (stall) begin
        stall_cnt_reg <= stall_sum[32] ? 32'hFFFF_FFFF : stall_sum[31:0];
      end
      kill_cnt_reg <= kill_sum[32] ? 32'hFFFF_FFFF : kill_sum[31:0];
    end
  end

  assign perf_stall_cnt = stall_cnt_reg;
  assign perf_kill_cnt  = kill_cnt_reg;
`endif

endmodule
